ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Receives raw PS/2 keyboard frames, validates them and tracks make/break scan-code sequences. Produces the last scan code, its ASCII value, a key-held flag and a BCD key-press count. These feed the seven-segment hex display stage directly downstream. Sits between the PS/2 connector pins and the display/VGA text logic.

## Interface
- TIMEOUT_CYCLES, 50000: idle `clk` cycles mid-frame after which a partial frame is discarded (1 ms at 50 MHz).
- clk  in  1  system clock; all logic runs on its rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- ps2_data  in  1  raw PS/2 data pin, asynchronous to `clk`.
- data  out  8  last valid byte received, including F0.
- ascii  out  8  ASCII of the most recent make code; 00 if unmapped.
- state  out  1  0 = a key is held; 1 = no key held.
- count  out  8  key-press count, two BCD digits: [7:4] tens, [3:0] units.
- ready  out  1  one-cycle pulse when a valid byte is accepted.
- frame_err  out  1  one-cycle pulse when a complete frame fails its checks.

One clock; reset is asynchronous and active-low.

## Operation
- **Input synchronisation:** `ps2_clk` and `ps2_data` pass through 3-flop synchronisers. A falling edge is synchronised-previous=1 and synchronised-current=0.
- **Frame capture:** on each falling edge, sample `ps2_data` into an 11-bit shift register, LSB first, and increment a bit counter 0..10.
  - Frame format: start=0, d0..d7, odd parity, stop=1.
- **Frame completion (11th edge):** the frame is valid iff start==0, stop==1 and the XOR of d0..d7 and parity is 1.
  - Valid: the byte goes to the key FSM and `ready` pulses.
  - Invalid: `frame_err` pulses and all other outputs hold.
  - The bit counter returns to 0 either way.
- **Timeout:** a counter clears on every falling edge. If it reaches TIMEOUT_CYCLES while the bit counter is non-zero, the bit counter clears and no pulse is generated.
- **Key FSM states:** IDLE (no key), HELD (key down), BREAK (F0 seen). Byte b is handled as follows:
  - IDLE, b≠F0, b≠E0: go to HELD. data=b, ascii=lut(b), state=0, count+1.
  - HELD, b==held code: auto-repeat. data=b; count, ascii and state unchanged.
  - HELD, b≠F0, b≠E0, b≠held code: stay in HELD. Held code=b, data=b, ascii=lut(b), count+1.
  - IDLE or HELD, b==F0: go to BREAK, data=F0. state unchanged.
  - BREAK, any b except E0: go to IDLE. data=b, state=1. ascii and count unchanged.
  - b==E0 in any state: ignored. No output change; `ready` still pulses.
- **Count:** BCD increment. Units 9→0 carries into tens; 99→00 wraps.
- **lut:** US-layout set-2 scan code to lowercase ASCII, covering letters, digits, space (29→20) and enter (5A→0D). All other codes map to 00.

## Timing
- Reset values: data=00, ascii=00, state=1, count=00, ready=0, frame_err=0, FSM=IDLE, bit counter=0, shift register=0.
- Falling-edge detection occurs 3 `clk` cycles after the pin transition.
- FSM update, output registers, and `ready`/`frame_err` all change in the same cycle, one cycle after the 11th edge is detected.
- All outputs are registered, with no combinational path from the pins.
- Reset asserted mid-frame aborts the frame immediately. A frame already in flight when reset releases is discarded by the timeout or a framing error, never accepted.
- A falling edge coinciding with timeout expiry: the edge wins, so the counter clears and the bit is sampled.
- `ps2_clk` ≤ 16.7 kHz assumes `clk` ≥ 1 MHz.

## Structure
- Shared package `ps2_pkg`: F0/E0 constants, the FSM state enum, and the frame-length constant 11.
- Sub-module `scan2ascii`: a combinational 8→8 lookup instantiated once. It is registered in the parent.

## Test plan
- Frame 1C (parity 0 on the wire, since 1C has three 1s) → data=1C, ascii=61, state=0, count=01, `ready` pulses once.
- 1C repeated 3 times → count stays 01, data=1C, three `ready` pulses.
- After holding 1C, send F0 then 1C:
  - After F0: data=F0, state=0.
  - After 1C: data=1C, state=1, ascii=61, count=01.
- Frame 1C with its parity bit inverted → `frame_err` one cycle; data, ascii, state and count unchanged.
- 100 make/break pairs of 32 → count reaches 99, then wraps to 00.
- 5 bits, then idle for TIMEOUT_CYCLES+10, then a full frame 45 → data=45, ascii=30, no `frame_err`.
- `clrn` low after bit 6 of a frame → all outputs return to reset values. The next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, key FSM states and BCD helper for the PS/2 key tracker
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam int         FRAME_LEN  = 11;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_HELD,
        KEY_BREAK
    } key_state_e;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/scan2ascii.sv
// rtl/scan2ascii.sv - set-2 make code to lowercase ASCII lookup, unmapped codes give 00
module scan2ascii (
    input  logic [7:0] scan_code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (scan_code)
            8'h1C: ascii = 8'h61;
            8'h32: ascii = 8'h62;
            8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;
            8'h24: ascii = 8'h65;
            8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;
            8'h33: ascii = 8'h68;
            8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;
            8'h42: ascii = 8'h6B;
            8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;
            8'h31: ascii = 8'h6E;
            8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;
            8'h15: ascii = 8'h71;
            8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;
            8'h2C: ascii = 8'h74;
            8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;
            8'h1D: ascii = 8'h77;
            8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;
            8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 frame receiver with make/break tracking, ASCII and BCD press count
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic [7:0] ascii,
    output logic       state,
    output logic [7:0] count,
    output logic       ready,
    output logic       frame_err
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]     LAST_BIT = 4'(FRAME_LEN - 1);

    logic [2:0]          clk_sync_q, clk_sync_d;
    logic [2:0]          dat_sync_q, dat_sync_d;
    logic [10:0]         shift_q, shift_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]       to_cnt_q, to_cnt_d;
    logic                done_q, done_d;
    key_state_e          key_q, key_d;
    logic [7:0]          held_q, held_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          ascii_q, ascii_d;
    logic                state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic                fall;
    logic [7:0]          rx_byte;
    logic                frame_ok;
    logic [7:0]          lut_ascii;

    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign rx_byte  = shift_q[8:1];
    // start low, stop high, odd parity across data and parity bits
    assign frame_ok = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);

    scan2ascii u_scan2ascii (
        .scan_code (rx_byte),
        .ascii     (lut_ascii)
    );

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk};
        dat_sync_d = {dat_sync_q[1:0], ps2_data};
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        to_cnt_d   = to_cnt_q;
        done_d     = 1'b0;
        key_d      = key_q;
        held_d     = held_q;
        data_d     = data_q;
        ascii_d    = ascii_q;
        state_d    = state_q;
        count_d    = count_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        // A falling edge takes priority over a simultaneous timeout expiry.
        if (fall) begin
            to_cnt_d = '0;
            shift_d  = {dat_sync_q[2], shift_q[10:1]};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            if (to_cnt_q == TO_LIMIT) begin
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end

        if (done_q) begin
            if (!frame_ok) begin
                err_d = 1'b1;
            end else begin
                ready_d = 1'b1;
                if (rx_byte != EXT_CODE) begin
                    case (key_q)
                        KEY_IDLE, KEY_HELD: begin
                            if (rx_byte == BREAK_CODE) begin
                                key_d  = KEY_BREAK;
                                data_d = rx_byte;
                            end else if (key_q == KEY_HELD && rx_byte == held_q) begin
                                data_d = rx_byte;
                            end else begin
                                key_d   = KEY_HELD;
                                held_d  = rx_byte;
                                data_d  = rx_byte;
                                ascii_d = lut_ascii;
                                state_d = 1'b0;
                                count_d = bcd_inc(count_q);
                            end
                        end
                        KEY_BREAK: begin
                            key_d   = KEY_IDLE;
                            data_d  = rx_byte;
                            state_d = 1'b1;
                        end
                        default: key_d = KEY_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 3'b111;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            to_cnt_q   <= '0;
            done_q     <= 1'b0;
            key_q      <= KEY_IDLE;
            held_q     <= '0;
            data_q     <= '0;
            ascii_q    <= '0;
            state_q    <= 1'b1;
            count_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= to_cnt_d;
            done_q     <= done_d;
            key_q      <= key_d;
            held_q     <= held_d;
            data_q     <= data_d;
            ascii_q    <= ascii_d;
            state_q    <= state_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign data      = data_q;
    assign ascii     = ascii_q;
    assign state     = state_q;
    assign count     = count_q;
    assign ready     = ready_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - randomized PS/2 stimulus checked against a byte-level key model
module tb_ps2_key_tracker;

    localparam int TO   = 200;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data;
    logic [7:0] ascii;
    logic       state;
    logic [7:0] count;
    logic       ready;
    logic       frame_err;

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (data),
        .ascii     (ascii),
        .state     (state),
        .count     (count),
        .ready     (ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int ready_pulses = 0;
    int err_pulses = 0;
    bit quiet = 1'b0;

    // model: what a user sees from the keyboard
    logic [7:0] exp_data, exp_ascii;
    logic       exp_state;
    int         presses;
    int         phase;      // 0 nothing held, 1 key down, 2 break prefix seen
    logic [7:0] held_code;

    string      lut_chars = "abcdefghijklmnopqrstuvwxyz0123456789";
    logic [7:0] lut_codes [0:35] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic logic [7:0] model_lut(input logic [7:0] b);
        if (b == 8'h29) return 8'h20;
        if (b == 8'h5A) return 8'h0D;
        for (int i = 0; i < 36; i++)
            if (lut_codes[i] == b) return lut_chars[i];
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_count();
        return {4'(presses / 10), 4'(presses % 10)};
    endfunction

    task automatic model_reset();
        exp_data = 8'h00; exp_ascii = 8'h00; exp_state = 1'b1;
        presses = 0; phase = 0; held_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) return;
        if (phase == 2) begin
            phase = 0; exp_data = b; exp_state = 1'b1;
        end else if (b == 8'hF0) begin
            phase = 2; exp_data = b;
        end else if (phase == 1 && b == held_code) begin
            exp_data = b;
        end else begin
            phase = 1; held_code = b; exp_data = b;
            exp_ascii = model_lut(b); exp_state = 1'b0;
            presses = (presses + 1) % 100;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string name);
        chk({name, ".data"},  {24'h0, data},  {24'h0, exp_data});
        chk({name, ".ascii"}, {24'h0, ascii}, {24'h0, exp_ascii});
        chk({name, ".state"}, {31'h0, state}, {31'h0, exp_state});
        chk({name, ".count"}, {24'h0, count}, {24'h0, exp_count()});
    endtask

    // Outside frame windows nothing may pulse and outputs must match the model.
    always @(negedge clk) begin
        if (ready) ready_pulses++;
        if (frame_err) err_pulses++;
        if (quiet && clrn)
            chk("steady", {5'h0, data, ascii, count, state, ready, frame_err},
                {5'h0, exp_data, exp_ascii, exp_count(), exp_state, 1'b0, 1'b0});
    end

    task automatic drive_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // fault: 0 none, 1 parity flipped, 2 start high, 3 stop low
    task automatic send_frame(input logic [7:0] b, input int fault);
        logic [10:0] f;
        int r0, e0;
        bit ok;
        ok = (fault == 0);
        f[0]   = (fault == 2);
        f[8:1] = b;
        f[9]   = ~(^b) ^ (fault == 1);
        f[10]  = (fault != 3);
        quiet = 1'b0;
        r0 = ready_pulses;
        e0 = err_pulses;
        for (int i = 0; i < 11; i++) drive_bit(f[i]);
        ps2_data = 1'b1;
        repeat (12) @(posedge clk);
        if (ok) model_byte(b);
        chk("ready_pulses", 32'(ready_pulses - r0), ok ? 32'd1 : 32'd0);
        chk("err_pulses",   32'(err_pulses - e0),   ok ? 32'd0 : 32'd1);
        chk_outputs("frame");
        quiet = 1'b1;
    endtask

    task automatic send_partial(input int nbits);
        drive_bit(1'b0);
        for (int i = 1; i < nbits; i++) drive_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic do_reset();
        quiet = 1'b0;
        @(negedge clk);
        clrn = 1'b0;
        model_reset();
        #1;
        chk("rst.data",  {24'h0, data},  32'h00);
        chk("rst.ascii", {24'h0, ascii}, 32'h00);
        chk("rst.state", {31'h0, state}, 32'h1);
        chk("rst.count", {24'h0, count}, 32'h00);
        chk("rst.pulse", {30'h0, ready, frame_err}, 32'h0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        quiet = 1'b1;
    endtask

    logic [7:0] pool [0:7] = '{8'h1C, 8'h32, 8'h45, 8'h29, 8'h5A, 8'h76, 8'hF0, 8'hE0};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        send_frame(8'h1C, 0);
        chk("lit.1c.data",  {24'h0, data},  32'h1C);
        chk("lit.1c.ascii", {24'h0, ascii}, 32'h61);
        chk("lit.1c.state", {31'h0, state}, 32'h0);
        chk("lit.1c.count", {24'h0, count}, 32'h01);

        repeat (3) send_frame(8'h1C, 0);
        chk("lit.rep.count", {24'h0, count}, 32'h01);

        send_frame(8'hF0, 0);
        chk("lit.f0.data",  {24'h0, data},  32'hF0);
        chk("lit.f0.state", {31'h0, state}, 32'h0);
        send_frame(8'h1C, 0);
        chk("lit.brk.data",  {24'h0, data},  32'h1C);
        chk("lit.brk.state", {31'h0, state}, 32'h1);
        chk("lit.brk.ascii", {24'h0, ascii}, 32'h61);
        chk("lit.brk.count", {24'h0, count}, 32'h01);

        send_frame(8'h1C, 1);
        chk("lit.perr.data", {24'h0, data}, 32'h1C);
        send_frame(8'h32, 2);
        send_frame(8'h32, 3);

        do_reset();
        for (int i = 1; i <= 100; i++) begin
            send_frame(8'h32, 0);
            send_frame(8'hF0, 0);
            send_frame(8'h32, 0);
            if (i == 99) chk("lit.count99", {24'h0, count}, 32'h99);
        end
        chk("lit.wrap", {24'h0, count}, 32'h00);

        send_partial(5);
        repeat (TO + 10) @(posedge clk);
        send_frame(8'h45, 0);
        chk("lit.to.data",  {24'h0, data},  32'h45);
        chk("lit.to.ascii", {24'h0, ascii}, 32'h30);

        send_partial(6);
        do_reset();
        send_frame(8'h1C, 0);
        chk("lit.postrst.count", {24'h0, count}, 32'h01);

        for (int i = 0; i < 60; i++) begin
            int f;
            f = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
            send_frame(pool[$urandom_range(0, 7)], f);
        end

        quiet = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
